// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loader_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects little-endian bytes into a 32-bit instruction word.
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              valid,
  output logic [WORD_W-1:0] word_c,
  output logic              word_full_c
);

  localparam int unsigned CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0]  byte_cnt;
  logic [WORD_W-1:0] word;

  // Word as it will look once the current byte is inserted.
  always_comb begin
    word_c = word;
    word_c[{byte_cnt, 3'b000} +: BYTE_W] = byte_data;
  end

  assign word_full_c = valid && (byte_cnt == CNT_W'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (valid) begin
      word     <= word_c;
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a word-count header plus instruction bytes into program memory,
// holding the core in reset while a load is in progress.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BYTE_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic [WORD_W-1:0]     mem_write_data,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned IDX_W     = ADDR_WIDTH - 2;
  localparam int unsigned MAX_WORDS = 1 << IDX_W;

  loader_state_e     state;
  loader_state_e     state_next_c;
  logic [IDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]  last_idx;
  logic              xfer_c;
  logic              header_bad_c;
  logic              asm_valid_c;
  logic              asm_clear_c;
  logic [WORD_W-1:0] word_c;
  logic              word_full_c;

  assign xfer_c       = rx_valid && rx_ready;
  assign header_bad_c = (rx_data == BYTE_W'(0)) || (32'(rx_data) > MAX_WORDS);
  assign asm_valid_c  = xfer_c && (state == DATA);
  assign asm_clear_c  = (state == HEADER);

  program_loader_word_assembler u_word_assembler (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (asm_clear_c),
    .byte_data   (rx_data),
    .valid       (asm_valid_c),
    .word_c      (word_c),
    .word_full_c (word_full_c)
  );

  // Next-state decode; start is only honoured in IDLE, DONE and ERROR.
  always_comb begin
    state_next_c = state;
    unique case (state)
      IDLE:        if (start) state_next_c = HEADER;
      HEADER:      if (xfer_c) state_next_c = header_bad_c ? ERROR : DATA;
      DATA:        if (word_full_c) state_next_c = WRITE;
      WRITE:       state_next_c = (word_idx == last_idx) ? DONE : DATA;
      DONE, ERROR: if (start) state_next_c = HEADER;
      default:     state_next_c = IDLE;
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state
  // so they are registered yet line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      word_idx         <= '0;
      last_idx         <= '0;
      rx_ready         <= 1'b0;
      mem_address      <= '0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= '0;
      cpu_reset_n      <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      state            <= state_next_c;
      rx_ready         <= (state_next_c == HEADER) || (state_next_c == DATA);
      busy             <= (state_next_c == HEADER) || (state_next_c == DATA) ||
                          (state_next_c == WRITE);
      done             <= (state_next_c == DONE);
      error            <= (state_next_c == ERROR);
      cpu_reset_n      <= (state_next_c == IDLE) || (state_next_c == DONE);
      mem_write_enable <= (state_next_c == WRITE);

      if (state == HEADER && xfer_c) begin
        word_idx <= '0;
        last_idx <= IDX_W'(rx_data - BYTE_W'(1));
      end

      if (state == DATA && word_full_c) begin
        mem_address    <= {word_idx, 2'b00};
        mem_write_data <= word_c;
      end

      if (state == WRITE && word_idx != last_idx) begin
        word_idx <= word_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with hand-computed expected values.
module tb_program_loader;

  localparam int unsigned ADDR_WIDTH = 5;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  start;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_write_enable;
  logic [31:0]           mem_write_data;
  logic                  cpu_reset_n;
  logic                  busy;
  logic                  done;
  logic                  error;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int ready_viol = 0;
  logic [7:0] pay [0:31];

  program_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .cpu_reset_n      (cpu_reset_n),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  // Strobe counter and rx_ready-during-write watch.
  always @(negedge clk) begin
    if (reset_n && mem_write_enable) begin
      strobe_cnt++;
      if (rx_ready) ready_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_we"},       32'(mem_write_enable), 32'd0);
    check({tag, "_addr"},     32'(mem_address), 32'd0);
    check({tag, "_data"},     mem_write_data, 32'd0);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_error"},    32'(error), 32'd0);
    check({tag, "_cpu_rst"},  32'(cpu_reset_n), 32'd0);
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte after `gap` idle cycles; returns just after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Header plus nwords words from pay[]; checks each write strobe the cycle after its 4th byte.
  task automatic load(input logic [7:0] hdr, input int nwords, input int gap,
                      input string tag, input bit poke);
    send_byte(hdr, gap);
    for (int w = 0; w < nwords; w++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(pay[4*w+k], gap);
        if (poke && w == 0 && k == 1) begin
          pulse_start;
          check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        end
      end
      check({tag, "_we"},       32'(mem_write_enable), 32'd1);
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
      check({tag, "_addr"},     32'(mem_address), 32'(4*w));
      check({tag, "_data"},     mem_write_data,
            {pay[4*w+3], pay[4*w+2], pay[4*w+1], pay[4*w]});
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("cpu_rst_release", 32'(cpu_reset_n), 32'd1);

    // Basic two-word load
    pay[0] = 8'h13; pay[1] = 8'h05; pay[2] = 8'h00; pay[3] = 8'h00;
    pay[4] = 8'h93; pay[5] = 8'h05; pay[6] = 8'h10; pay[7] = 8'h00;
    pulse_start;
    check("basic_busy",     32'(busy), 32'd1);
    check("basic_cpu_held", 32'(cpu_reset_n), 32'd0);
    check("basic_rx_ready", 32'(rx_ready), 32'd1);
    send_byte(8'h02, 0);
    for (int k = 0; k < 4; k++) send_byte(pay[k], 0);
    check("basic_w0_data", mem_write_data, 32'h00000513);
    check("basic_w0_addr", 32'(mem_address), 32'h00);
    for (int k = 4; k < 8; k++) send_byte(pay[k], 0);
    check("basic_w1_data", mem_write_data, 32'h00100593);
    check("basic_w1_addr", 32'(mem_address), 32'h04);
    wait_done("basic");
    check("basic_cpu_run",  32'(cpu_reset_n), 32'd1);
    check("basic_idle",     32'(busy), 32'd0);
    check("basic_strobes",  32'(strobe_cnt), 32'd2);
    check("basic_hold",     mem_write_data, 32'h00100593);

    // Restart from DONE, then the same stream with gaps between bytes
    pulse_start;
    check("restart_done", 32'(done), 32'd0);
    check("restart_cpu",  32'(cpu_reset_n), 32'd0);
    load(8'h02, 2, 3, "gap", 1'b0);
    wait_done("gap");
    check("gap_strobes", 32'(strobe_cnt), 32'd4);

    // Bad headers
    pulse_start;
    send_byte(8'h00, 0);
    check("hdr0_error",    32'(error), 32'd1);
    check("hdr0_rx_ready", 32'(rx_ready), 32'd0);
    check("hdr0_cpu",      32'(cpu_reset_n), 32'd0);
    check("hdr0_busy",     32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("hdr0_stay",     32'(error), 32'd1);
    check("hdr0_strobes",  32'(strobe_cnt), 32'd4);
    pulse_start;
    check("err_clear",     32'(error), 32'd0);
    check("err_busy",      32'(busy), 32'd1);
    send_byte(8'h09, 0);
    check("hdr9_error",    32'(error), 32'd1);
    check("hdr9_rx_ready", 32'(rx_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("hdr9_strobes",  32'(strobe_cnt), 32'd4);

    // Full capacity from ERROR
    for (int i = 0; i < 32; i++) pay[i] = 8'(i * 29 + 7);
    pulse_start;
    load(8'h08, 8, 0, "full", 1'b0);
    check("full_last_addr", 32'(mem_address), 32'h1C);
    wait_done("full");
    check("full_strobes", 32'(strobe_cnt), 32'd12);

    // Reset after two bytes of word 1, with start in the same cycle
    for (int i = 0; i < 8; i++) pay[i] = 8'(8'hA0 + i);
    pulse_start;
    load(8'h02, 1, 0, "mid", 1'b0);
    send_byte(pay[4], 0);
    send_byte(pay[5], 0);
    @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_strobes", 32'(strobe_cnt), 32'd13);
    check("midrst_idle",    32'(busy), 32'd0);

    // Reload with start pulsed during DATA
    pulse_start;
    load(8'h02, 2, 0, "reload", 1'b1);
    wait_done("reload");
    check("reload_strobes", 32'(strobe_cnt), 32'd15);
    check("ready_during_write", 32'(ready_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
